// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: ALU op codes, alu_op classes,
// FSM state enum and a helper to classify shift operations.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_AND  = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1010,
    OP_SLTU = 4'b1011
  } alu_op_e;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of alu_op/funct3/funct7 into the internal ALU op code.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  output alu_op_e    op_o
);

  always_comb begin
    op_o = OP_ADD;
    case (alu_op_i)
      ALUOP_LDST: op_o = OP_ADD;
      ALUOP_BRANCH: begin
        case (funct3_i)
          3'b000, 3'b001: op_o = OP_SUB;
          3'b100, 3'b101: op_o = OP_SLT;
          3'b110, 3'b111: op_o = OP_SLTU;
          default:        op_o = OP_ADD;
        endcase
      end
      default: begin
        case (funct3_i)
          // Immediate forms have no SUB: funct7 only selects SUB for R-type.
          3'b000:  op_o = (alu_op_i == ALUOP_RTYPE && funct7_i) ? OP_SUB : OP_ADD;
          3'b001:  op_o = OP_SLL;
          3'b010:  op_o = OP_SLT;
          3'b011:  op_o = OP_SLTU;
          3'b100:  op_o = OP_XOR;
          3'b101:  op_o = funct7_i ? OP_SRA : OP_SRL;
          3'b110:  op_o = OP_OR;
          default: op_o = OP_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit with optional bit-serial shifter.
// Handshake: a transfer occurs on a rising edge where valid & ready are both high; valid holds its payload until then.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output alu_state_e      dbg_state_o
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  alu_op_e         dec_op;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] step_res;
  logic            accept;

  alu_op_decode u_decode (
    .alu_op_i (alu_op),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .op_o     (dec_op)
  );

  assign shamt       = op_b[SHW-1:0];
  assign in_ready    = (state_q == ST_IDLE) && !flush;
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign zero        = out_valid && (result_q == '0);
  assign dbg_state_o = state_q;

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  // One serial step of the shift held in result_q; SRA re-copies the sign bit.
  always_comb begin
    step_res = result_q;
    case (op_q)
      OP_SLL:  step_res = {result_q[XLEN-2:0], 1'b0};
      OP_SRL:  step_res = {1'b0, result_q[XLEN-1:1]};
      OP_SRA:  step_res = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: step_res = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d = dec_op;
            if (SERIAL_SHIFT != 0 && is_shift(dec_op) && shamt != '0) begin
              state_d  = ST_SHIFT;
              result_d = op_a;
              cnt_d    = shamt;
            end else begin
              state_d  = ST_DONE;
              result_d = alu_res;
            end
          end
        end
        ST_SHIFT: begin
          result_d = step_res;
          cnt_d    = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, operand/result width (power of 2, >=8).
REQ-002 SHALL have parameter SERIAL_SHIFT, 1, 1 = shifts take 1 bit/cycle; 0 = single-cycle barrel shift.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid  input  1  operands/control present.
REQ-007 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-008 SHALL have port alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-009 SHALL have port funct3  input  3  instruction funct3.
REQ-010 SHALL have port funct7  input  1  instruction funct7 bit 5.
REQ-011 SHALL have port op_a, op_b  input  XLEN each  operands.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  XLEN  operation result.
REQ-015 SHALL have port zero  output  1  result == 0, valid with out_valid.

Function
REQ-016 Op codes SHALL be: ADD 0000, SUB 0001, SLL 0010, OR 0011, AND 0100, XOR 0101, SRL 0110, SRA 0111, SLT 1010, SLTU 1011.
REQ-017 Decode SHALL map: alu_op 00 -> ADD; 01 -> funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU, 010/011 ADD.
REQ-018 alu_op 10 SHALL map funct3 000 ADD/SUB by funct7, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7, 110 OR, 111 AND.
REQ-019 alu_op 11 SHALL decode as alu_op 10 except funct3 000 is always ADD (funct7 ignored).
REQ-020 Shift amount SHALL be op_b[log2(XLEN)-1:0]; upper bits ignored.
REQ-021 ADD/SUB SHALL wrap modulo 2^XLEN; SLT signed, SLTU unsigned, result zero-extended 0/1.
REQ-022 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state == IDLE) and not flush.
REQ-023 Handshake SHALL be accepted on edge where in_valid & in_ready; op, operands latched.
REQ-024 Non-shift op, or any shift with SERIAL_SHIFT=0 or amount 0: IDLE -> DONE, out_valid high 1 cycle after acceptance.
REQ-025 Serial shift of amount k>0: IDLE -> SHIFT, one bit per cycle, -> DONE after k cycles; out_valid at acceptance+k+1.
REQ-026 SRA SHALL replicate the sign bit on every serial step.
REQ-027 DONE SHALL hold result, zero, out_valid stable until out_valid & out_ready, then -> IDLE.
REQ-028 No new operation SHALL be accepted in SHIFT or DONE (no back-to-back overlap).
REQ-029 flush SHALL force IDLE next edge from any state, drop out_valid, and win over simultaneous in_valid.
REQ-030 Invalid input SHALL not alter state; in_valid while not ready SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, zero 0, shift counter 0.
REQ-032 Reset mid-shift or in DONE SHALL discard the operation; in_ready high on first edge after release.

Structure
REQ-033 Op codes, alu_op encodings and FSM state enum SHALL live in shared package alu_pkg.
REQ-034 Decode SHALL be sub-module alu_op_decode (combinational: alu_op, funct3, funct7 -> 4-bit op).

Verification
REQ-035 ADD 0x7FFFFFFF+1 (alu_op 10, f3 000, f7 0) -> result 0x80000000, zero 0, out_valid 1 cycle after accept.
REQ-036 BEQ SUB 5-5 (alu_op 01, f3 000) -> result 0, zero 1; SLT -1 vs 1 -> 1, SLTU -> 0.
REQ-037 SRA 0x80000000 by 4, SERIAL_SHIFT=1 -> 0xF8000000 at accept+5; by 0 -> accept+1.
REQ-038 Result with out_ready low 3 cycles -> result/out_valid stable, in_ready 0 throughout; consumed -> in_ready 1 next cycle.
REQ-039 flush at cycle 2 of SLL by 10 -> out_valid never asserts, IDLE next edge; flush with in_valid -> not accepted.
REQ-040 rst_n low mid-shift -> outputs 0 asynchronously; XLEN=64, SERIAL_SHIFT=0 SLL 1 by 63 -> 0x8000000000000000.
